// File: rtl/rf_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Build option: RF_WB_BYPASS_EN (see rf_wb_arbiter.sv).
package rf_wb_arbiter_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   localparam int NUM_REGS   = 32;
   localparam int PEND_CNT_W = 6;
   localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

   // Arbiter state: NORMAL lets the pipe win, HOLD forces one mc grant.
   typedef enum logic {
      ARB_NORMAL = 1'b0,
      ARB_HOLD   = 1'b1
   } arb_state_t;

   // Number of set bits in a register mask.
   function automatic logic [PEND_CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
      logic [PEND_CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         n = n + PEND_CNT_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Writeback sources feeding the arbiter: the pipe write (no backpressure)
// and the multi-cycle unit result handshake.
// Build option: RF_WB_BYPASS_EN has no effect on this interface.
//
// Handshake: the mc result transfers on a cycle where mc_valid && mc_ready
// are both high at the rising edge; mc_valid/mc_wa/mc_wd must stay stable
// until that cycle. mc_ready is combinational from the current inputs and
// arbiter state. pipe_we has no ready: when pipe_stall is high the
// writeback stage keeps its write and presents it again.
interface rf_wb_arbiter_if;
   import rf_wb_arbiter_pkg::*;

   logic                  pipe_we;
   logic [REG_ADDR_W-1:0] pipe_wa;
   logic [REG_DATA_W-1:0] pipe_wd;
   logic                  mc_valid;
   logic [REG_ADDR_W-1:0] mc_wa;
   logic [REG_DATA_W-1:0] mc_wd;
   logic                  mc_ready;

   modport master (
      output pipe_we, pipe_wa, pipe_wd, mc_valid, mc_wa, mc_wd,
      input  mc_ready
   );

   modport slave (
      input  pipe_we, pipe_wa, pipe_wd, mc_valid, mc_wa, mc_wd,
      output mc_ready
   );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-register scoreboard for in-flight mc ops: set on issue, clear on
// mc commit, registered popcount and the decode hazard lookup.
// Build option: RF_WB_BYPASS_EN masks a same-cycle clear out of the hazard.
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_v,
   input  logic [REG_ADDR_W-1:0] set_wa,
   input  logic                  clr_v,
   input  logic [REG_ADDR_W-1:0] clr_wa,
   input  logic [REG_ADDR_W-1:0] ra1,
   input  logic [REG_ADDR_W-1:0] ra2,
   input  logic [REG_ADDR_W-1:0] wa,
   input  logic                  wa_v,
   output logic [NUM_REGS-1:0]   pending,
   output logic [PEND_CNT_W-1:0] pend_cnt,
   output logic                  hz
);

   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic [NUM_REGS-1:0] pending_next;
   logic [NUM_REGS-1:0] pend_view;

   // Build set/clear masks; set is applied after clear so it wins on a tie.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_v && set_wa != ZERO_REG) set_mask[set_wa] = 1'b1;
      if (clr_v)                       clr_mask[clr_wa] = 1'b1;
      pending_next = (pending & ~clr_mask) | set_mask;
   end

   // Pending vector and its population count, both registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending  <= '0;
         pend_cnt <= '0;
      end else begin
         pending  <= pending_next;
         pend_cnt <= popcount(pending_next);
      end
   end

   // Hazard view: with the bypass, a register completing this cycle is
   // already readable, so it no longer blocks decode.
   always_comb begin
`ifdef RF_WB_BYPASS_EN
      pend_view = pending & ~clr_mask;
`else
      pend_view = pending;
`endif
      hz = (pend_view[ra1] && ra1 != ZERO_REG) ||
           (pend_view[ra2] && ra2 != ZERO_REG) ||
           (wa_v && pend_view[wa] && wa != ZERO_REG);
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port arbiter between the pipe writeback and the
// multi-cycle unit, with starvation hold, pending scoreboard and a sticky
// protocol error flag.
// Build option: RF_WB_BYPASS_EN forwards the granted write to rd1/rd2 and
// lets a completing mc result clear the decode hazard in its commit cycle.
// STARVE_MAX must be 1..15 and below 2**CNT_W.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4,
   parameter int CNT_W      = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   rf_wb_arbiter_if.slave        wb,
   input  logic                  issue_v,
   input  logic [REG_ADDR_W-1:0] issue_wa,
   input  logic [REG_ADDR_W-1:0] dec_ra1,
   input  logic [REG_ADDR_W-1:0] dec_ra2,
   input  logic [REG_ADDR_W-1:0] dec_wa,
   input  logic                  dec_wa_v,
   output logic                  pipe_stall,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_wa,
   output logic [REG_DATA_W-1:0] rf_wd,
   input  logic [REG_DATA_W-1:0] rf_rd1_in,
   input  logic [REG_DATA_W-1:0] rf_rd2_in,
   output logic [REG_DATA_W-1:0] rd1,
   output logic [REG_DATA_W-1:0] rd2,
   output logic [PEND_CNT_W-1:0] pend_cnt,
   output logic                  err,
   output arb_state_t            dbg_state
);

   arb_state_t          state;
   arb_state_t          state_next;
   logic                hold;
   logic                pe;
   logic                me;
   logic                grant_pipe;
   logic                mc_hs;
   logic [CNT_W-1:0]    starve_cnt;
   logic [CNT_W-1:0]    starve_next;
   logic [NUM_REGS-1:0] pending;
   logic                hz;
   logic                err_hit;

   assign hold      = (state == ARB_HOLD);
   assign dbg_state = state;

   // Grant and write-port mux: the pipe wins unless a hold forces mc through.
   always_comb begin
      pe          = wb.pipe_we && wb.pipe_wa != ZERO_REG;
      me          = wb.mc_valid;
      wb.mc_ready = hold || !pe;
      grant_pipe  = pe && !hold;
      mc_hs       = me && wb.mc_ready;
      if (grant_pipe) begin
         rf_we = 1'b1;
         rf_wa = wb.pipe_wa;
         rf_wd = wb.pipe_wd;
      end else begin
         rf_we = mc_hs && wb.mc_wa != ZERO_REG;
         rf_wa = wb.mc_wa;
         rf_wd = wb.mc_wd;
      end
   end

   // Count consecutive denied mc cycles, saturating; any grant or idle resets.
   always_comb begin
      starve_next = '0;
      if (me && !wb.mc_ready) begin
         starve_next = (starve_cnt == {CNT_W{1'b1}}) ? starve_cnt
                                                      : starve_cnt + CNT_W'(1);
      end
   end

   // Enter HOLD for exactly one cycle once the denial run reaches the limit.
   always_comb begin
      state_next = ARB_NORMAL;
      if (state == ARB_NORMAL && me && starve_next == CNT_W'(STARVE_MAX)) begin
         state_next = ARB_HOLD;
      end
   end

   // Arbiter state and starvation counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_NORMAL;
         starve_cnt <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
      end
   end

   rf_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_v    (issue_v),
      .set_wa   (issue_wa),
      .clr_v    (mc_hs),
      .clr_wa   (wb.mc_wa),
      .ra1      (dec_ra1),
      .ra2      (dec_ra2),
      .wa       (dec_wa),
      .wa_v     (dec_wa_v),
      .pending  (pending),
      .pend_cnt (pend_cnt),
      .hz       (hz)
   );

   assign pipe_stall = hz || hold;

   // Protocol violations: pipe overwriting an in-flight destination, a second
   // issue to a still-pending register, or an mc result nobody was waiting for.
   always_comb begin
      err_hit = 1'b0;
      if (grant_pipe && pending[wb.pipe_wa]) err_hit = 1'b1;
      if (issue_v && issue_wa != ZERO_REG && pending[issue_wa] &&
          !(mc_hs && wb.mc_wa == issue_wa)) err_hit = 1'b1;
      if (mc_hs && wb.mc_wa != ZERO_REG && !pending[wb.mc_wa]) err_hit = 1'b1;
   end

   // Sticky error flag, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else        err <= err || err_hit;
   end

   // Decode read data, optionally forwarded from this cycle's register write.
   always_comb begin
`ifdef RF_WB_BYPASS_EN
      rd1 = (rf_we && rf_wa == dec_ra1 && dec_ra1 != ZERO_REG) ? rf_wd : rf_rd1_in;
      rd2 = (rf_we && rf_wa == dec_ra2 && dec_ra2 != ZERO_REG) ? rf_wd : rf_rd2_in;
`else
      rd1 = rf_rd1_in;
      rd2 = rf_rd2_in;
`endif
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed sequences plus a random
// legal-traffic phase, predicted by a cycle-level behavioural model and
// compared by an independent monitor on the falling clock edge.
// Build option: RF_WB_BYPASS_EN selects the bypass expectations.
module tb_rf_wb_arbiter;
   import rf_wb_arbiter_pkg::*;

   localparam int STARVE_MAX = 4;
   localparam int CNT_W      = 4;
   localparam int CNT_SAT    = 15;
`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // clock / reset
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rf_wb_arbiter_if wb ();
   logic        issue_v;
   logic [4:0]  issue_wa;
   logic [4:0]  dec_ra1, dec_ra2, dec_wa;
   logic        dec_wa_v;
   logic        pipe_stall;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [31:0] rf_rd1_in, rf_rd2_in;
   logic [31:0] rd1, rd2;
   logic [5:0]  pend_cnt;
   logic        err;
   arb_state_t  dbg_state;

   rf_wb_arbiter #(.STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb         (wb),
      .issue_v    (issue_v),
      .issue_wa   (issue_wa),
      .dec_ra1    (dec_ra1),
      .dec_ra2    (dec_ra2),
      .dec_wa     (dec_wa),
      .dec_wa_v   (dec_wa_v),
      .pipe_stall (pipe_stall),
      .rf_we      (rf_we),
      .rf_wa      (rf_wa),
      .rf_wd      (rf_wd),
      .rf_rd1_in  (rf_rd1_in),
      .rf_rd2_in  (rf_rd2_in),
      .rd1        (rd1),
      .rd2        (rd2),
      .pend_cnt   (pend_cnt),
      .err        (err),
      .dbg_state  (dbg_state)
   );

   // scoreboard
   typedef struct {
      logic        we;
      logic        ready;
      logic        stall;
      logic [5:0]  cnt;
      logic        err;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic        hold;
   } exp_t;

   exp_t        stat_q[$];
   logic [36:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   // behavioural model state
   bit m_pend[32];
   bit m_err;
   int m_denied;
   bit m_hold;
   bit m_last_hs;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_count();
      int n = 0;
      for (int i = 1; i < 32; i++) n += int'(m_pend[i]);
      return n;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_err = 1'b0;
      m_denied = 0;
      m_hold = 1'b0;
      m_last_hs = 1'b0;
   endtask

   task automatic idle_inputs();
      wb.pipe_we = 1'b0; wb.pipe_wa = '0; wb.pipe_wd = '0;
      wb.mc_valid = 1'b0; wb.mc_wa = '0; wb.mc_wd = '0;
      issue_v = 1'b0; issue_wa = '0;
      dec_ra1 = '0; dec_ra2 = '0; dec_wa = '0; dec_wa_v = 1'b0;
      rf_rd1_in = $urandom; rf_rd2_in = $urandom;
   endtask

   // Driver: inputs are already applied; predict this cycle, then advance.
   task automatic step();
      exp_t        e;
      bit          pe, me, hs, hz, w_v;
      logic [4:0]  w_a;
      logic [31:0] w_d;
      pe = wb.pipe_we && wb.pipe_wa != 0;
      me = wb.mc_valid;
      e.ready = m_hold ? 1'b1 : !pe;
      hs = me && e.ready;
      w_v = 1'b0; w_a = wb.mc_wa; w_d = wb.mc_wd;
      if (pe && !m_hold) begin
         w_v = 1'b1; w_a = wb.pipe_wa; w_d = wb.pipe_wd;
      end else if (hs && wb.mc_wa != 0) begin
         w_v = 1'b1;
      end
      hz = 1'b0;
      if (dec_ra1 != 0 && m_pend[dec_ra1] && !(BYP && hs && wb.mc_wa == dec_ra1)) hz = 1'b1;
      if (dec_ra2 != 0 && m_pend[dec_ra2] && !(BYP && hs && wb.mc_wa == dec_ra2)) hz = 1'b1;
      if (dec_wa_v && dec_wa != 0 && m_pend[dec_wa] && !(BYP && hs && wb.mc_wa == dec_wa)) hz = 1'b1;
      e.we    = w_v;
      e.stall = hz || m_hold;
      e.cnt   = 6'(model_count());
      e.err   = m_err;
      e.rd1   = (BYP && w_v && w_a == dec_ra1 && dec_ra1 != 0) ? w_d : rf_rd1_in;
      e.rd2   = (BYP && w_v && w_a == dec_ra2 && dec_ra2 != 0) ? w_d : rf_rd2_in;
      e.hold  = m_hold;
      stat_q.push_back(e);
      if (w_v) exp_q.push_back({w_a, w_d});
      // next-state of the model
      if (pe && !m_hold && m_pend[wb.pipe_wa]) m_err = 1'b1;
      if (issue_v && issue_wa != 0 && m_pend[issue_wa] && !(hs && wb.mc_wa == issue_wa)) m_err = 1'b1;
      if (hs && wb.mc_wa != 0 && !m_pend[wb.mc_wa]) m_err = 1'b1;
      if (hs) m_pend[wb.mc_wa] = 1'b0;
      if (issue_v && issue_wa != 0) m_pend[issue_wa] = 1'b1;
      if (me && !e.ready) m_denied = (m_denied < CNT_SAT) ? m_denied + 1 : CNT_SAT;
      else                m_denied = 0;
      m_hold = (m_denied == STARVE_MAX) && me && !m_hold;
      m_last_hs = hs;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset in the middle of a cycle; check it takes effect at once.
   task automatic do_reset();
      #2;
      wb.pipe_we = 1'b0; wb.mc_valid = 1'b0; issue_v = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_pend_cnt", pend_cnt, 0);
      check("rst_stall", pipe_stall, 0);
      check("rst_err", err, 0);
      check("rst_hold", dbg_state == ARB_HOLD, 0);
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Monitor: pop the predicted status every active cycle and compare.
   always @(negedge clk) begin
      exp_t        e;
      logic [36:0] w;
      if (rst_n && stat_q.size() > 0) begin
         e = stat_q.pop_front();
         check("rf_we", rf_we, e.we);
         check("mc_ready", wb.mc_ready, e.ready);
         check("pipe_stall", pipe_stall, e.stall);
         check("pend_cnt", pend_cnt, e.cnt);
         check("err", err, e.err);
         check("rd1", rd1, e.rd1);
         check("rd2", rd2, e.rd2);
         check("hold", dbg_state == ARB_HOLD, e.hold);
         if (rf_we) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rf_write actual=%0h expected=none", {rf_wa, rf_wd});
            end else begin
               w = exp_q.pop_front();
               check("rf_write", {rf_wa, rf_wd}, w);
            end
         end
      end
   end

   // Watchdog: the stimulus is bounded, but never let a run hang.
   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          mc_busy;
      logic [4:0]  mc_a;
      logic [31:0] mc_d;
      int          plist[$];
      idle_inputs();
      model_clear();
      rst_n = 1'b0;
      #3;
      check("init_pend_cnt", pend_cnt, 0);
      check("init_stall", pipe_stall, 0);
      check("init_err", err, 0);
      check("init_rf_we", rf_we, 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // priority: pipe beats mc, mc goes next cycle
      issue_v = 1'b1; issue_wa = 5'd7; step();
      issue_v = 1'b0;
      wb.pipe_we = 1'b1; wb.pipe_wa = 5'd5; wb.pipe_wd = 32'h0000_AAAA;
      wb.mc_valid = 1'b1; wb.mc_wa = 5'd7; wb.mc_wd = 32'h7777_0007;
      step();
      wb.pipe_we = 1'b0; step();
      idle_inputs(); step();

      // starvation: pipe writes every cycle while mc waits
      issue_v = 1'b1; issue_wa = 5'd10; step();
      issue_v = 1'b0;
      mc_busy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         wb.pipe_we = 1'b1; wb.pipe_wa = 5'(1 + i % 8); wb.pipe_wd = $urandom;
         wb.mc_valid = mc_busy; wb.mc_wa = 5'd10; wb.mc_wd = 32'hC0DE_000A;
         step();
         if (m_last_hs) mc_busy = 1'b0;
      end
      idle_inputs(); step();

      // scoreboard stall until the mc result for r9 commits
      issue_v = 1'b1; issue_wa = 5'd9; step();
      issue_v = 1'b0; dec_ra1 = 5'd9; rf_rd1_in = 32'h0BAD_0BAD;
      repeat (3) step();
      wb.mc_valid = 1'b1; wb.mc_wa = 5'd9; wb.mc_wd = 32'h1234_5678;
      step();
      wb.mc_valid = 1'b0;
      step();
      step();
      idle_inputs(); step();

      // same-cycle set and clear of r3
      issue_v = 1'b1; issue_wa = 5'd3; step();
      wb.mc_valid = 1'b1; wb.mc_wa = 5'd3; wb.mc_wd = 32'h3333_3333;
      step();
      idle_inputs(); dec_ra2 = 5'd3; step();
      wb.mc_valid = 1'b1; wb.mc_wa = 5'd3; wb.mc_wd = 32'h3030_3030; step();
      idle_inputs(); step();

      // reset with r4 pending and decode reading it
      issue_v = 1'b1; issue_wa = 5'd4; step();
      issue_v = 1'b0; dec_ra1 = 5'd4; step();
      do_reset();
      idle_inputs(); step();

      // random legal traffic
      mc_busy = 1'b0; mc_a = '0; mc_d = '0;
      for (int c = 0; c < 400; c++) begin
         if (!mc_busy && $urandom_range(0, 2) == 0) begin
            plist.delete();
            for (int i = 1; i < 32; i++) if (m_pend[i]) plist.push_back(i);
            if (plist.size() > 0) begin
               mc_a = 5'(plist[$urandom_range(0, plist.size() - 1)]);
               mc_d = $urandom;
               mc_busy = 1'b1;
            end
         end
         wb.mc_valid = mc_busy; wb.mc_wa = mc_a; wb.mc_wd = mc_d;
         wb.pipe_we = ($urandom_range(0, 3) != 0);
         wb.pipe_wa = 5'($urandom_range(0, 31));
         if (m_pend[wb.pipe_wa]) wb.pipe_wa = '0;
         wb.pipe_wd = $urandom;
         issue_v = ($urandom_range(0, 3) == 0);
         issue_wa = 5'($urandom_range(0, 31));
         if (m_pend[issue_wa]) issue_v = 1'b0;
         dec_ra1 = 5'($urandom_range(0, 31));
         dec_ra2 = 5'($urandom_range(0, 31));
         dec_wa = 5'($urandom_range(0, 31));
         dec_wa_v = $urandom_range(0, 1);
         rf_rd1_in = $urandom; rf_rd2_in = $urandom;
         step();
         if (m_last_hs) mc_busy = 1'b0;
      end
      idle_inputs(); step();
      do_reset();

      // zero register: issue to r0 sets nothing, mc to r0 is taken and dropped
      idle_inputs(); issue_v = 1'b1; issue_wa = 5'd0; step();
      idle_inputs(); wb.mc_valid = 1'b1; wb.mc_wa = 5'd0; wb.mc_wd = 32'hDEAD_0000; step();
      idle_inputs(); step();

      // error: mc result for a non-pending register, stays sticky
      wb.mc_valid = 1'b1; wb.mc_wa = 5'd12; wb.mc_wd = 32'h0000_0C0C; step();
      idle_inputs(); repeat (3) step();
      do_reset();

      // error: second issue to a pending register
      idle_inputs(); issue_v = 1'b1; issue_wa = 5'd6; step();
      step();
      idle_inputs(); dec_wa_v = 1'b1; dec_wa = 5'd6; step();
      do_reset();

      // error: pipe write to a pending register
      idle_inputs(); issue_v = 1'b1; issue_wa = 5'd8; step();
      idle_inputs(); wb.pipe_we = 1'b1; wb.pipe_wa = 5'd8; wb.pipe_wd = 32'h8888_8888; step();
      idle_inputs(); step();
      step();

      check("stat_q_drained", stat_q.size(), 0);
      check("exp_q_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (pipe) and a multi-cycle unit (mc: mult/div, uncached load).
- Keeps a 32-entry pending scoreboard for registers targeted by in-flight mc ops and raises a decode stall on RAW/WAW hazards against them.
- Sits between writeback/decode and the register file: drives its we/wa/wd and optionally bypasses its asynchronous read data.

Parameters:
- STARVE_MAX, 4: consecutive denied mc cycles before the pipe is held for one cycle to force an mc grant; legal range 1..15.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_MAX.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pipe_we  in  1  pipe writeback valid; no backpressure
- pipe_wa  in  5  pipe write address
- pipe_wd  in  32  pipe write data
- mc_valid  in  1  mc result valid
- mc_wa  in  5  mc write address
- mc_wd  in  32  mc write data
- mc_ready  out  1  mc result accepted this cycle
- issue_v  in  1  mc op issued this cycle (decode not stalled)
- issue_wa  in  5  destination of the issued mc op
- dec_ra1, dec_ra2  in  5 each  decode source addresses
- dec_wa  in  5  decode destination address
- dec_wa_v  in  1  decode instruction writes a register
- pipe_stall  out  1  freeze decode and writeback
- rf_we  out  1  to register file
- rf_wa  out  5  to register file
- rf_wd  out  32  to register file
- rf_rd1_in, rf_rd2_in  in  32 each  register file read data
- rd1, rd2  out  32 each  read data to decode
- pend_cnt  out  6  number of pending registers
- err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0): pending=0, starve_cnt=0, hold=0, err=0, so pend_cnt=0 and pipe_stall=0. rf_we=0 whenever neither source requests.
- Effective pipe write: pe = pipe_we && pipe_wa!=0. Effective mc request: me = mc_valid. A write from mc to address 0 is accepted and dropped (rf_we=0).
- Arbitration is combinational, zero latency. With hold=0, pipe wins: mc_ready = !pe. With hold=1, mc wins: mc_ready=1 and the pipe write is not performed.
  - While hold=1, pipe_stall=1, so the writeback stage keeps its write and re-presents it the next cycle.
- Port drive: rf_we/rf_wa/rf_wd come from the granted source; rf_we=0 if the granted address is 0.
- Starvation counter, on each rising edge:
  - me && !mc_ready: starve_cnt++, saturating.
  - mc handshake (me && mc_ready) or !me: starve_cnt=0.
  - hold is registered: hold(next) = (starve_cnt(next) == STARVE_MAX) && me && !hold; hold is never high two consecutive cycles.
- Scoreboard, on each rising edge:
  - mc handshake clears pending[mc_wa].
  - issue_v && issue_wa!=0 sets pending[issue_wa].
  - Set and clear to the same address in the same cycle: set wins.
  - pend_cnt is the registered popcount of pending.
- Hazard, combinational:
  - hz = (pending[dec_ra1] && dec_ra1!=0) || (pending[dec_ra2] && dec_ra2!=0) || (dec_wa_v && pending[dec_wa] && dec_wa!=0).
  - pipe_stall = hz || hold.
- Same-cycle clear: a register cleared by an mc handshake this cycle still reports pending this cycle. Its data becomes visible through the bypass, or the next cycle without it.
- err is set (sticky until reset) when any of these occurs:
  - pipe write commits to a pending register;
  - issue_v to an already-pending register without a same-cycle clear;
  - mc handshake to a non-pending nonzero register.
- Reset mid-operation: all pending entries are lost; the mc unit is reset by the same rst_n.

Optional Feature:
- RF_WB_BYPASS_EN defined: rd1 = (rf_we && rf_wa==dec_ra1 && dec_ra1!=0) ? rf_wd : rf_rd1_in; rd2 likewise.
  - The hazard term uses pending with the same-cycle mc clear masked out, so a completing mc result resolves the stall in its commit cycle.
- Not defined: rd1=rf_rd1_in, rd2=rf_rd2_in; hazard as specified above, so one extra stall cycle after mc commit.

Decomposition:
- Shared package: REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, ZERO_REG=0.
- One sub-module: rf_scoreboard, holding the pending vector, set/clear/popcount and the hazard lookup. Arbitration, starvation logic and bypass stay in the top.

Test Plan:
- Reset: rst_n low mid-cycle with pending=0x0000_0010 -> pending=0, pend_cnt=0, pipe_stall=0, err=0, immediately and asynchronously.
- Priority: pipe_we=1 wa=5 wd=0xAAAA and mc_valid=1 wa=7 in the same cycle -> rf_we=1, rf_wa=5, mc_ready=0. Next cycle with pipe_we=0 -> rf_wa=7, mc_ready=1.
- Starvation: STARVE_MAX=4, pipe_we=1 every cycle, mc_valid held -> mc denied for 4 cycles, hold=1 in cycle 5 with mc granted and pipe_stall=1, then pipe resumes.
- Scoreboard: issue_v wa=9; decode dec_ra1=9 -> pipe_stall=1 until mc commits wa=9.
  - Without bypass: stall drops the cycle after commit.
  - With RF_WB_BYPASS_EN: stall drops in the commit cycle and rd1=mc_wd.
- Same-cycle set and clear: mc commits wa=3 while issue_v wa=3 -> pending[3] remains 1, err=0, pend_cnt unchanged.
- Errors and zero register: mc commit wa=12 while not pending -> err=1 and stays set. issue_v wa=0 -> no pending set. mc commit wa=0 -> mc_ready=1, rf_we=0.
